// File: rtl/gesture_pkg.sv
// Shared types and constants for the gesture-driven servo driver.
package gesture_pkg;

    localparam int unsigned GESTURE_W       = 8;
    localparam int unsigned RELEASE_ALL_BIT = 7;

    typedef logic [GESTURE_W-1:0] gesture_t;

    typedef enum logic {IDLE, MOVING} drv_state_t;

endpackage

// File: rtl/servo_channel.sv
// One servo: open/closed target, rate-limited position slew and registered PWM compare.
module servo_channel #(
    parameter int unsigned CW          = 20,
    parameter int unsigned OPEN_PULSE  = 50000,
    parameter int unsigned CLOSE_PULSE = 100000,
    parameter int unsigned STEP_CYCLES = 2500
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick_i,
    input  logic          load_i,
    input  logic          close_i,
    input  logic [CW-1:0] frame_cnt_i,
    output logic          pwm_o,
    output logic          match_o
);

    localparam logic [CW-1:0] OpenW  = CW'(OPEN_PULSE);
    localparam logic [CW-1:0] CloseW = CW'(CLOSE_PULSE);
    localparam logic [CW-1:0] StepW  = CW'(STEP_CYCLES);

    logic [CW-1:0] target_q, target_d;
    logic [CW-1:0] pos_q, pos_d;
    logic [CW-1:0] diff;
    logic          up;
    logic          pwm_q;

    always_comb begin
        target_d = target_q;
        if (load_i) begin
            target_d = close_i ? CloseW : OpenW;
        end

        // Magnitude plus direction keeps the subtraction unsigned.
        up   = (target_q > pos_q);
        diff = up ? (target_q - pos_q) : (pos_q - target_q);

        // Slew uses the registered target, so a same-cycle gesture waits a frame.
        pos_d = pos_q;
        if (frame_tick_i) begin
            if (diff <= StepW) begin
                pos_d = target_q;
            end else if (up) begin
                pos_d = pos_q + StepW;
            end else begin
                pos_d = pos_q - StepW;
            end
        end
    end

    assign match_o = (pos_d == target_d);
    assign pwm_o   = pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= OpenW;
            pos_q    <= OpenW;
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            pos_q    <= pos_d;
            pwm_q    <= (frame_cnt_i < pos_q);
        end
    end

endmodule

// File: rtl/gesture_servo_driver.sv
// Gesture pulses to per-finger servo targets; shared PWM frame counter, decode and busy FSM.
module gesture_servo_driver
    import gesture_pkg::*;
#(
    parameter int unsigned NUM_SERVOS    = 5,
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter int unsigned OPEN_PULSE    = 50000,
    parameter int unsigned CLOSE_PULSE   = 100000,
    parameter int unsigned STEP_CYCLES   = 2500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  gesture_t              gesture,
    output logic [NUM_SERVOS-1:0] pwm,
    output logic                  busy,
    output logic                  frame_tick
);

    localparam int unsigned CW = $clog2(PERIOD_CYCLES);

    if (!(OPEN_PULSE < CLOSE_PULSE && CLOSE_PULSE < PERIOD_CYCLES)) begin : g_bad_pulse
        $error("gesture_servo_driver: need OPEN_PULSE < CLOSE_PULSE < PERIOD_CYCLES");
    end
    if (STEP_CYCLES < 1) begin : g_bad_step
        $error("gesture_servo_driver: STEP_CYCLES must be at least 1");
    end
    if (NUM_SERVOS > 7) begin : g_bad_num
        $error("gesture_servo_driver: NUM_SERVOS must be at most 7");
    end

    logic [CW-1:0]         frame_cnt_q, frame_cnt_d;
    logic                  load;
    logic [NUM_SERVOS-1:0] close;
    logic [NUM_SERVOS-1:0] match;
    drv_state_t            state_q, state_d;

    assign frame_tick  = (frame_cnt_q == CW'(PERIOD_CYCLES - 1));
    assign frame_cnt_d = frame_tick ? '0 : frame_cnt_q + 1'b1;

    // Bit 7 forces all-open, since an all-zero pattern is the idle code.
    assign load  = (gesture != '0);
    assign close = gesture[RELEASE_ALL_BIT] ? '0 : gesture[NUM_SERVOS-1:0];

    for (genvar i = 0; i < NUM_SERVOS; i++) begin : g_ch
        servo_channel #(
            .CW          (CW),
            .OPEN_PULSE  (OPEN_PULSE),
            .CLOSE_PULSE (CLOSE_PULSE),
            .STEP_CYCLES (STEP_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .frame_tick_i (frame_tick),
            .load_i       (load),
            .close_i      (close[i]),
            .frame_cnt_i  (frame_cnt_q),
            .pwm_o        (pwm[i]),
            .match_o      (match[i])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!(&match)) state_d = MOVING;
            end
            MOVING: begin
                if (frame_tick && (&match)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == MOVING);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            state_q     <= IDLE;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            state_q     <= state_d;
        end
    end

endmodule
